// File: rtl/move_command_transmitter_pkg.sv
// Shared encodings and code timing (in code units) for the IR move-command transmitter.
// CMD_PARITY_EN appends an even-parity bit to every frame.
package move_command_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_GAP   = 3'd2,
      ST_BIT   = 3'd3,
      ST_PAD   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int START_UNITS = 4;
   localparam int ONE_UNITS   = 2;
   localparam int ZERO_UNITS  = 1;
   localparam int GAP_UNITS   = 1;
   localparam int CMD_WIDTH   = 12;

`ifdef CMD_PARITY_EN
   localparam int FRAME_BITS = CMD_WIDTH + 1;
`else
   localparam int FRAME_BITS = CMD_WIDTH;
`endif

   function automatic logic is_burst(input state_e s);
      return (s == ST_START) || (s == ST_BIT);
   endfunction

endpackage

// File: rtl/move_command_transmitter_ir_carrier_gen.sv
// IR carrier: high for HALF cycles after restart, then toggling every HALF cycles while enabled.
module ir_carrier_gen #(
   parameter int HALF = 337
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic carrier_out
);

   localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [HW-1:0] phase_q;
   logic          out_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         out_q   <= 1'b0;
      end else if (!enable) begin
         phase_q <= '0;
         out_q   <= 1'b0;
      end else if (restart) begin
         phase_q <= '0;
         out_q   <= 1'b1;
      end else if (phase_q == HW'(HALF - 1)) begin
         phase_q <= '0;
         out_q   <= ~out_q;
      end else begin
         phase_q <= phase_q + HW'(1);
      end
   end

   assign carrier_out = out_q;

endmodule

// File: rtl/move_command_transmitter.sv
// Sends a 12-bit move command as a SIRC-style pulse-width IR frame, LSB first, REPEATS times.
// CMD_PARITY_EN adds a 13th even-parity bit after bit 11.
module move_command_transmitter
   import move_command_transmitter_pkg::*;
#(
   parameter int CLK_HZ     = 27_000_000,
   parameter int CARRIER_HZ = 40_000,
   parameter int UNIT_US    = 600,
   parameter int FRAME_US   = 45_000,
   parameter int REPEATS    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        send,
   input  logic [11:0] command,
   output logic        busy,
   output logic        done,
   output logic        ir_out,
   output logic [2:0]  state
);

   localparam int HALF  = CLK_HZ / (2 * CARRIER_HZ);
   localparam int UNIT  = CLK_HZ / 1_000_000 * UNIT_US;
   localparam int FRAME = CLK_HZ / 1_000_000 * FRAME_US;
   localparam int UW    = $clog2(2 * UNIT + 1);
   localparam int FW    = $clog2(FRAME);
   localparam int RW    = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam int BW    = $clog2(FRAME_BITS + 1);

   state_e                state_q, state_d;
   logic [UW-1:0]         cyc_q;
   logic [2:0]            units_q;
   logic [FW-1:0]         frame_q;
   logic [RW-1:0]         rep_q;
   logic [BW-1:0]         bit_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic [FRAME_BITS-1:0] load_d;
   logic [2:0]            len_d;
   logic                  seg_end_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic                  burst_d, restart_d;

`ifdef CMD_PARITY_EN
   assign load_d = {^command, command};
`else
   assign load_d = command;
`endif

   // Segment length in units; a segment ends on the last cycle of its last unit.
   always_comb begin
      len_d = 3'(GAP_UNITS);
      case (state_q)
         ST_START: len_d = 3'(START_UNITS);
         ST_BIT:   len_d = shift_q[0] ? 3'(ONE_UNITS) : 3'(ZERO_UNITS);
         default:  len_d = 3'(GAP_UNITS);
      endcase
      seg_end_d = (cyc_q == UW'(UNIT - 1)) && (units_q == (len_d - 3'd1));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = send ? ST_START : ST_IDLE;
         ST_START: state_d = seg_end_d ? ST_GAP : ST_START;
         ST_GAP: begin
            if (!seg_end_d)                      state_d = ST_GAP;
            else if (bit_q == BW'(FRAME_BITS))   state_d = ST_PAD;
            else                                 state_d = ST_BIT;
         end
         ST_BIT:   state_d = seg_end_d ? ST_GAP : ST_BIT;
         ST_PAD: begin
            if (frame_q != FW'(FRAME - 1))       state_d = ST_PAD;
            else if (rep_q == RW'(REPEATS - 1))  state_d = ST_DONE;
            else                                 state_d = ST_START;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered versions line up with state_q.
   always_comb begin
      burst_d   = is_burst(state_d);
      restart_d = burst_d && !is_burst(state_q);
      busy_d    = (state_d == ST_START) || (state_d == ST_GAP) ||
                  (state_d == ST_BIT)   || (state_d == ST_PAD);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc_q   <= '0;
         units_q <= '0;
         frame_q <= '0;
         rep_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         if (state_d != state_q) begin
            cyc_q   <= '0;
            units_q <= '0;
         end else if (cyc_q == UW'(UNIT - 1)) begin
            cyc_q   <= '0;
            units_q <= units_q + 3'd1;
         end else begin
            cyc_q   <= cyc_q + UW'(1);
         end

         if (state_d == ST_START && state_q != ST_START) begin
            frame_q <= '0;
         end else if (frame_q != FW'(FRAME - 1)) begin
            frame_q <= frame_q + FW'(1);
         end

         if (state_d == ST_START) begin
            bit_q <= '0;
         end else if (state_q == ST_BIT && state_d == ST_GAP) begin
            bit_q <= bit_q + BW'(1);
         end

         // Rotating (not shifting) leaves the payload intact for the next repeat.
         if (state_q == ST_IDLE && state_d == ST_START) begin
            shift_q <= load_d;
            rep_q   <= '0;
         end else if (state_q == ST_BIT && state_d == ST_GAP) begin
            shift_q <= {shift_q[0], shift_q[FRAME_BITS-1:1]};
         end else if (state_q == ST_PAD && state_d == ST_START) begin
            rep_q   <= rep_q + RW'(1);
         end
      end
   end

   ir_carrier_gen #(.HALF(HALF)) u_carrier (
      .clock       (clock),
      .reset       (reset),
      .restart     (restart_d),
      .enable      (burst_d),
      .carrier_out (ir_out)
   );

   assign busy  = busy_q;
   assign done  = done_q;
   assign state = state_q;

endmodule

// File: tb/tb_move_command_transmitter.sv
// Directed bench for move_command_transmitter at UNIT=10, HALF=5, FRAME=500, REPEATS=3.
module tb_move_command_transmitter;

   localparam int FRAME_C = 500;
   localparam int REP_C   = 3;
`ifdef CMD_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        send = 1'b0;
   logic [11:0] command = 12'h000;
   logic        busy, done, ir_out;
   logic [2:0]  state;

   int vectors = 0;
   int miscompares = 0;

   move_command_transmitter #(
      .CLK_HZ(1_000_000), .CARRIER_HZ(100_000), .UNIT_US(10), .FRAME_US(500), .REPEATS(3)
   ) dut (
      .clock(clock), .reset(reset), .send(send), .command(command),
      .busy(busy), .done(done), .ir_out(ir_out), .state(state)
   );

   always #5 clock = ~clock;

   // Expected ir_out at cycle c of a frame: 40-cycle start, then per bit a 10-cycle gap and a 20/10-cycle burst.
   function automatic logic exp_ir(input int c, input logic [12:0] b);
      int t;
      int w;
      if (c < 40) return (((c / 5) % 2) == 0) ? 1'b1 : 1'b0;
      t = 40;
      for (int i = 0; i < NB; i++) begin
         t = t + 10;
         w = b[i] ? 20 : 10;
         if (c >= t && c < t + w) return ((((c - t) / 5) % 2) == 0) ? 1'b1 : 1'b0;
         t = t + w;
      end
      return 1'b0;
   endfunction

   task automatic accept(input logic [11:0] cmd, input bit hold);
      send = 1'b1;
      command = cmd;
      @(negedge clock);
      if (!hold) send = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL accept_busy: got %b want 1", busy); end
      vectors++;
      if (ir_out !== 1'b1) begin miscompares++; $display("FAIL accept_ir: got %b want 1", ir_out); end
   endtask

   // Entry: current negedge shows frame cycle 0. Checks all frames, the done cycle and the following IDLE cycle.
   task automatic check_frames(input logic [11:0] cmd, input int poke_at);
      logic [12:0] bits;
      int ir_bad, first_bad, busy_bad, done_bad, abs_c;
      bits = {1'b0, cmd};
`ifdef CMD_PARITY_EN
      bits[12] = ^cmd;
`endif
      busy_bad = 0;
      done_bad = 0;
      for (int f = 0; f < REP_C; f++) begin
         ir_bad = 0;
         first_bad = -1;
         for (int c = 0; c < FRAME_C; c++) begin
            if (f > 0 || c > 0) @(negedge clock);
            abs_c = f * FRAME_C + c;
            if (abs_c == poke_at) begin
               send = 1'b1;
               command = 12'hFFF;
            end else if (abs_c == poke_at + 1) begin
               send = 1'b0;
            end
            if (ir_out !== exp_ir(c, bits)) begin
               if (ir_bad == 0) first_bad = c;
               ir_bad++;
            end
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if (c == 0) begin
               vectors++;
               if (state !== 3'd1) begin miscompares++; $display("FAIL frame%0d_start_state: got %0d want 1", f, state); end
            end
            if (c == FRAME_C - 1) begin
               vectors++;
               if (state !== 3'd4) begin miscompares++; $display("FAIL frame%0d_pad_state: got %0d want 4", f, state); end
            end
         end
         vectors++;
         if (ir_bad !== 0) begin
            miscompares++;
            $display("FAIL frame%0d_ir cmd=%h: %0d bad cycles, first at %0d, want 0", f, cmd, ir_bad, first_bad);
         end
      end
      vectors++;
      if (busy_bad !== 0) begin miscompares++; $display("FAIL busy_in_frames: %0d low cycles, want 0", busy_bad); end
      vectors++;
      if (done_bad !== 0) begin miscompares++; $display("FAIL done_early: %0d high cycles, want 0", done_bad); end
      @(negedge clock);
      vectors++;
      if (done !== 1'b1) begin miscompares++; $display("FAIL done_pulse: got %b want 1", done); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy); end
      vectors++;
      if (state !== 3'd5) begin miscompares++; $display("FAIL done_state: got %0d want 5", state); end
      @(negedge clock);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b want 0", done); end
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL idle_after_done: got %0d want 0", state); end
      vectors++;
      if (ir_out !== 1'b0) begin miscompares++; $display("FAIL ir_idle: got %b want 0", ir_out); end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      vectors++;
      if ({busy, done, ir_out, state} !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b done=%b ir=%b state=%0d want all 0", busy, done, ir_out, state);
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (state !== 3'd0) begin miscompares++; $display("FAIL idle_after_reset: got %0d want 0", state); end
   endtask

   task automatic test_reset_mid_bit;
      accept(12'h005, 1'b0);
      repeat (52) @(negedge clock);
      vectors++;
      if (state !== 3'd3 || ir_out !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_bit: got state=%0d ir=%b want 3/1", state, ir_out);
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({busy, ir_out, state} !== 5'b00000) begin
         miscompares++;
         $display("FAIL async_reset: got busy=%b ir=%b state=%0d want 0/0/0", busy, ir_out, state);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single_command;
      accept(12'h005, 1'b0);
      command = 12'hFFF;
      check_frames(12'h005, 200);
   endtask

   task automatic test_all_ones;
      accept(12'hFFF, 1'b0);
      check_frames(12'hFFF, -10);
`ifdef CMD_PARITY_EN
      accept(12'h001, 1'b0);
      check_frames(12'h001, -10);
`endif
   endtask

   task automatic test_back_to_back;
      accept(12'h00A, 1'b1);
      check_frames(12'h00A, -10);
      @(negedge clock);
      vectors++;
      if (state !== 3'd1 || ir_out !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL back_to_back_restart: got state=%0d ir=%b busy=%b want 1/1/1", state, ir_out, busy);
      end
      send = 1'b0;
      check_frames(12'h00A, -10);
   endtask

   initial begin
      test_reset();
      test_reset_mid_bit();
      test_single_command();
      test_all_ones();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
